jtag_dr_bank: RTL and testbench

- Parametrised bank of NUM_REGS JTAG user data registers, WIDTH bits each, clocked by TCK.
- Replaces three separate fixed 8-bit std_reg instances behind tap_top.
- All registers share one capture/shift/update path.
- Adds three things the fixed register lacks: read-back capture mode, per-register update strobes, and shift-length checking with optional update suppression.

---
 rtl/jtag_dr_bank.sv | 129 ++++++++++++
 tb/tb_jtag_dr_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: bank of NUM_REGS JTAG user data registers sharing one
// capture/shift/update path. The bank adds a read-back capture mode,
// per-register update strobes, and shift-length checking with optional
// update suppression.
module jtag_dr_bank #(
   parameter int                          WIDTH      = 8,
   parameter int                          NUM_REGS   = 3,
   parameter logic [NUM_REGS*WIDTH-1:0]   RST_VAL    = '0,
   parameter bit                          STRICT_LEN = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NUM_REGS-1:0]           i_sel,
   input  logic                          i_capturedr,
   input  logic                          i_shiftdr,
   input  logic                          i_updatedr,
   input  logic                          i_mode,
   input  logic [NUM_REGS*WIDTH-1:0]     i_regin,
   input  logic                          i_si,
   input  logic                          i_err_clr,
   output logic                          o_so,
   output logic [NUM_REGS*WIDTH-1:0]     o_regout,
   output logic [NUM_REGS-1:0]           o_upd_pulse,
   output logic                          o_len_err,
   output logic                          o_sel_err
);

   localparam int TW = NUM_REGS * WIDTH;
   // Counter must hold WIDTH+1 so an over-long shift is distinguishable.
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

   logic [TW-1:0]       hold_q, hold_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_REGS-1:0] upd_q, upd_d;
   logic                len_q, len_d;
   logic                sel_err_q, sel_err_d;

   logic                sel_multi;
   logic                sel_valid;
   logic [WIDTH-1:0]    hold_sel;
   logic [WIDTH-1:0]    regin_sel;
   logic                len_ok;

   // Decode the select: one-hot check and the slices of the chosen register.
   always_comb begin
      sel_multi = (i_sel & (i_sel - NUM_REGS'(1))) != '0;
      sel_valid = (i_sel != '0) && !sel_multi;
      hold_sel  = '0;
      regin_sel = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (i_sel[k]) begin
            hold_sel  = hold_sel  | hold_q[k*WIDTH +: WIDTH];
            regin_sel = regin_sel | i_regin[k*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state for the shared path; capture outranks shift, shift outranks update.
   always_comb begin
      hold_d    = hold_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      upd_d     = '0;
      len_d     = 1'b0;
      len_ok    = (cnt_q == CNT_FULL);
      sel_err_d = sel_err_q;

      if (i_err_clr) begin
         sel_err_d = 1'b0;
      end else if (sel_multi && (i_capturedr || i_shiftdr || i_updatedr)) begin
         sel_err_d = 1'b1;
      end

      if (sel_valid) begin
         if (i_capturedr) begin
            shift_d = i_mode ? hold_sel : regin_sel;
            cnt_d   = '0;
         end else if (i_shiftdr) begin
            shift_d = {i_si, shift_q[WIDTH-1:1]};
            if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CW'(1);
            end
         end else if (i_updatedr) begin
            // Counter is left alone so a repeated update re-runs the same check.
            if (len_ok || !STRICT_LEN) begin
               for (int k = 0; k < NUM_REGS; k++) begin
                  if (i_sel[k]) begin
                     hold_d[k*WIDTH +: WIDTH] = shift_q;
                  end
               end
               upd_d = i_sel;
            end
            len_d = !len_ok;
         end
      end
   end

   // State registers; reset aborts any shift in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_q    <= RST_VAL;
         shift_q   <= '0;
         cnt_q     <= '0;
         upd_q     <= '0;
         len_q     <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         upd_q     <= upd_d;
         len_q     <= len_d;
         sel_err_q <= sel_err_d;
      end
   end

   // Serial out is the shift LSB, so the first captured bit shows with no latency.
   always_comb begin
      o_so        = sel_valid & shift_q[0];
      o_regout    = hold_q;
      o_upd_pulse = upd_q;
      o_len_err   = len_q;
      o_sel_err   = sel_err_q;
   end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Bench for jtag_dr_bank: a strict and a non-strict instance driven by the
// same inputs, checked against table vectors, hand sequences and a model.
module tb_jtag_dr_bank;

   localparam int          W  = 8;
   localparam int          N  = 3;
   localparam logic [23:0] RV = 24'h030201;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  sel;
   logic        cap, sh, upd, mode, si, clr;
   logic [23:0] regin;

   logic        so_a, len_a, selerr_a;
   logic [23:0] regout_a;
   logic [2:0]  updp_a;
   logic        so_b, len_b, selerr_b;
   logic [23:0] regout_b;
   logic [2:0]  updp_b;

   jtag_dr_bank #(.WIDTH(W), .NUM_REGS(N), .RST_VAL(RV), .STRICT_LEN(1'b1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_capturedr(cap),
      .i_shiftdr(sh), .i_updatedr(upd), .i_mode(mode), .i_regin(regin),
      .i_si(si), .i_err_clr(clr), .o_so(so_a), .o_regout(regout_a),
      .o_upd_pulse(updp_a), .o_len_err(len_a), .o_sel_err(selerr_a));

   jtag_dr_bank #(.WIDTH(W), .NUM_REGS(N), .RST_VAL(RV), .STRICT_LEN(1'b0)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_capturedr(cap),
      .i_shiftdr(sh), .i_updatedr(upd), .i_mode(mode), .i_regin(regin),
      .i_si(si), .i_err_clr(clr), .o_so(so_b), .o_regout(regout_b),
      .o_upd_pulse(updp_b), .o_len_err(len_b), .o_sel_err(selerr_b));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model, index 0 = strict instance, 1 = non-strict instance.
   logic [7:0] m_hold [2][3];
   logic [7:0] m_shift[2];
   int         m_cnt  [2];
   logic [2:0] m_upd  [2];
   logic       m_len  [2];
   logic       m_selerr[2];

   logic       last_so_a, last_so_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] m_regout(input int s);
      return {m_hold[s][2], m_hold[s][1], m_hold[s][0]};
   endfunction

   function automatic logic m_so(input int s, input logic [2:0] s_sel);
      if ($countones(s_sel) != 1) return 1'b0;
      return m_shift[s][0];
   endfunction

   task automatic model_reset();
      logic [23:0] rv;
      rv = RV;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 3; k++) m_hold[s][k] = rv[k*8 +: 8];
         m_shift[s]  = 8'h00;
         m_cnt[s]    = 0;
         m_upd[s]    = 3'b000;
         m_len[s]    = 1'b0;
         m_selerr[s] = 1'b0;
      end
   endtask

   task automatic model_step(input logic [2:0] s_sel, input logic c, h, u, md, d, cl);
      int ones;
      int k;
      ones = $countones(s_sel);
      k = 0;
      for (int i = 0; i < 3; i++) if (s_sel[i]) k = i;
      for (int s = 0; s < 2; s++) begin
         m_upd[s] = 3'b000;
         m_len[s] = 1'b0;
         if (cl) m_selerr[s] = 1'b0;
         else if (ones > 1 && (c || h || u)) m_selerr[s] = 1'b1;
         if (ones == 1) begin
            if (c) begin
               m_shift[s] = md ? m_hold[s][k] : regin[k*8 +: 8];
               m_cnt[s]   = 0;
            end else if (h) begin
               m_shift[s] = (m_shift[s] / 2) + (d ? 8'd128 : 8'd0);
               if (m_cnt[s] < W + 1) m_cnt[s] = m_cnt[s] + 1;
            end else if (u) begin
               if (m_cnt[s] == W || s == 1) begin
                  m_hold[s][k] = m_shift[s];
                  m_upd[s][k]  = 1'b1;
               end
               m_len[s] = (m_cnt[s] != W);
            end
         end
      end
   endtask

   task automatic check_state();
      check("regout_strict",  regout_a, m_regout(0));
      check("upd_strict",     updp_a,   m_upd[0]);
      check("len_strict",     len_a,    m_len[0]);
      check("selerr_strict",  selerr_a, m_selerr[0]);
      check("regout_loose",   regout_b, m_regout(1));
      check("upd_loose",      updp_b,   m_upd[1]);
      check("len_loose",      len_b,    m_len[1]);
      check("selerr_loose",   selerr_b, m_selerr[1]);
   endtask

   // One TCK cycle: apply inputs, check serial out, clock, check registered state.
   task automatic cycle(input logic [2:0] s_sel, input logic c, h, u, md, d, cl);
      sel = s_sel; cap = c; sh = h; upd = u; mode = md; si = d; clr = cl;
      #1;
      last_so_a = so_a;
      last_so_b = so_b;
      check("so_strict", so_a, m_so(0, s_sel));
      check("so_loose",  so_b, m_so(1, s_sel));
      @(posedge clk);
      model_step(s_sel, c, h, u, md, d, cl);
      #1;
      check_state();
   endtask

   task automatic idle_inputs();
      sel = 3'b000; cap = 0; sh = 0; upd = 0; mode = 0; si = 0; clr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_state();
      check("so_rst_strict", so_a, 1'b0);
      check("so_rst_loose",  so_b, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [2:0]  sel;
      logic        c, h, u, md, d;
      logic        exp_so;
      logic [23:0] exp_regout;
      logic [2:0]  exp_upd;
   } vec_t;

   vec_t tbl[11];

   function automatic logic [2:0] pick_sel();
      logic [2:0] opts[7];
      opts = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b011, 3'b101, 3'b111};
      return opts[$urandom_range(0, 6)];
   endfunction

   initial begin
      logic [7:0]  din, dout, stream;
      logic [2:0]  rs;
      int          nsh;
      logic        rc, rh, ru;

      idle_inputs();
      regin = 24'h0000AB;
      rst_n = 1'b1;
      #3;

      // Reset state
      do_reset();
      check("reset_regout", regout_a, 24'h030201);

      // Table: capture 0xAB into reg0, shift in 0x11, update
      din  = 8'h11;
      dout = 8'hAB;
      tbl[0] = '{3'b001, 1, 0, 0, 0, 0, 1'b0, 24'h030201, 3'b000};
      for (int i = 0; i < 8; i++)
         tbl[1+i] = '{3'b001, 0, 1, 0, 0, din[i], dout[i], 24'h030201, 3'b000};
      tbl[9]  = '{3'b001, 0, 0, 1, 0, 0, 1'b1, 24'h030211, 3'b001};
      tbl[10] = '{3'b001, 0, 0, 0, 0, 0, 1'b1, 24'h030211, 3'b000};
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].sel, tbl[i].c, tbl[i].h, tbl[i].u, tbl[i].md, tbl[i].d, 1'b0);
         check($sformatf("tbl%0d_so", i),     last_so_a, tbl[i].exp_so);
         check($sformatf("tbl%0d_regout", i), regout_a,  tbl[i].exp_regout);
         check($sformatf("tbl%0d_upd", i),    updp_a,    tbl[i].exp_upd);
      end

      // Read-back capture of reg2
      cycle(3'b100, 1, 0, 0, 1, 0, 0);
      stream = 8'h00;
      for (int i = 0; i < 8; i++) begin
         cycle(3'b100, 0, 1, 0, 0, 0, 0);
         stream[i] = last_so_a;
      end
      check("readback_stream", stream, 8'h03);
      cycle(3'b100, 0, 0, 1, 0, 0, 0);
      check("readback_regout", regout_a, 24'h000211);
      check("readback_upd",    updp_a,   3'b100);

      // Short shift into reg1: strict suppresses, loose updates, both flag length
      cycle(3'b010, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) cycle(3'b010, 0, 1, 0, 0, 1, 0);
      cycle(3'b010, 0, 0, 1, 0, 0, 0);
      check("short_len_strict",    len_a,    1'b1);
      check("short_upd_strict",    updp_a,   3'b000);
      check("short_regout_strict", regout_a, 24'h000211);
      check("short_len_loose",     len_b,    1'b1);
      check("short_upd_loose",     updp_b,   3'b010);
      check("short_regout_loose",  regout_b, 24'h00FE11);
      cycle(3'b010, 0, 0, 0, 0, 0, 0);
      check("short_len_drop", len_a, 1'b0);
      cycle(3'b010, 0, 0, 1, 0, 0, 0);
      check("short_len_repeat", len_a, 1'b1);

      // Multi-hot select: no effect, sticky error, clear
      cycle(3'b011, 1, 0, 0, 0, 0, 0);
      check("multi_so", last_so_a, 1'b0);
      check("multi_selerr", selerr_a, 1'b1);
      for (int i = 0; i < 3; i++) cycle(3'b011, 0, 1, 0, 0, 1, 0);
      cycle(3'b011, 0, 0, 1, 0, 0, 0);
      check("multi_regout", regout_a, 24'h000211);
      cycle(3'b000, 0, 0, 0, 0, 0, 0);
      check("multi_sticky", selerr_a, 1'b1);
      cycle(3'b011, 0, 1, 0, 0, 0, 1);
      check("multi_clear_wins", selerr_a, 1'b0);

      // Reset in the middle of a shift
      cycle(3'b001, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(3'b001, 0, 1, 0, 0, 1, 0);
      do_reset();
      check("midreset_regout_strict", regout_a, 24'h030201);
      check("midreset_regout_loose",  regout_b, 24'h030201);
      din = 8'h5A;
      cycle(3'b001, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(3'b001, 0, 1, 0, 0, din[i], 0);
      cycle(3'b001, 0, 0, 1, 0, 0, 0);
      check("postreset_regout", regout_a, 24'h03025A);
      check("postreset_upd",    updp_a,   3'b001);

      // Randomized traffic against the model
      for (int b = 0; b < 60; b++) begin
         regin = 24'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
               rs  = pick_sel();
               nsh = $urandom_range(6, 10);
               cycle(rs, 1, 0, 0, 1'($urandom), 0, 0);
               for (int i = 0; i < nsh; i++) cycle(rs, 0, 1, 0, 0, 1'($urandom), 0);
               cycle(rs, 0, 0, 1, 0, 0, 0);
               if ($urandom_range(0, 3) == 0) cycle(rs, 0, 0, 1, 0, 0, 0);
               cycle(rs, 0, 0, 0, 0, 0, 0);
            end
            5, 6, 7: begin
               for (int i = 0; i < 5; i++) begin
                  rs = pick_sel();
                  rc = ($urandom_range(0, 3) == 0);
                  rh = ($urandom_range(0, 1) == 0);
                  ru = ($urandom_range(0, 3) == 0);
                  cycle(rs, rc, rh, ru, 1'($urandom), 1'($urandom), 0);
               end
            end
            8: cycle(pick_sel(), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1);
            default: do_reset();
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
